// File: rtl/level_sequencer_pkg.sv
// Shared game definitions: sequencer states, level destination table and
// default sizing constants used by the level sequencer.
package level_sequencer_pkg;

  localparam int DEFAULT_NUM_LEVELS  = 4;
  localparam int DEFAULT_HOLD_FRAMES = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_HOLD,
    ST_WON
  } seq_state_t;

  typedef struct packed {
    logic [11:0] hPos;
    logic [11:0] vPos;
    logic [3:0]  color;
  } level_entry_t;

  // Indices beyond the populated table fall back to the first level.
  function automatic level_entry_t levelEntry(input logic [3:0] idx);
    level_entry_t entry;
    case (idx)
      4'd1:    entry = '{hPos: 12'd500, vPos: 12'd300, color: 4'd4};
      4'd2:    entry = '{hPos: 12'd620, vPos: 12'd420, color: 4'd9};
      4'd3:    entry = '{hPos: 12'd40,  vPos: 12'd440, color: 4'd12};
      default: entry = '{hPos: 12'd100, vPos: 12'd80,  color: 4'd2};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/level_sequencer_edge_detect.sv
// Rising-edge detector with a registered history bit that can be cleared
// synchronously.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else if (i_clear) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: walks through the destination table, holds a blinking
// completion display between levels and reports the win condition.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int NUM_LEVELS  = DEFAULT_NUM_LEVELS,
  parameter int HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_frame_tick,
  input  logic        i_level_complete,
  output logic [11:0] o_dest_hPos,
  output logic [11:0] o_dest_vPos,
  output logic [3:0]  o_rect_color,
  output logic        o_visible,
  output logic [3:0]  o_level_num,
  output logic        o_player_reset,
  output logic        o_game_won
);

  localparam logic [7:0] LAST_FRAME = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);

  seq_state_t   r_state;
  logic [3:0]   r_levelNum;
  logic [7:0]   r_frameCnt;
  logic [11:0]  r_destH;
  logic [11:0]  r_destV;
  logic [3:0]   r_color;
  logic         r_visible;
  logic         r_playerReset;
  logic         r_gameWon;

  logic         w_rise;
  logic         w_holdDone;
  logic         w_lastLevel;
  logic         w_enterLoad;
  logic [7:0]   w_frameNext;
  level_entry_t w_entry;

  assign w_holdDone  = (r_state == ST_HOLD) && i_frame_tick && (r_frameCnt == LAST_FRAME);
  assign w_lastLevel = (r_levelNum == LAST_LEVEL);
  assign w_frameNext = r_frameCnt + 8'd1;
  assign w_entry     = levelEntry(r_levelNum);

  // History is zeroed on the way into LOAD, so during LOAD it re-samples the
  // flag; a flag still high from the previous level then shows no edge in PLAY.
  assign w_enterLoad = (((r_state == ST_IDLE) || (r_state == ST_WON)) && i_start)
                     || (w_holdDone && !w_lastLevel);

  edge_detect u_completeEdge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_enterLoad),
    .i_sig   (i_level_complete),
    .o_rise  (w_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_levelNum    <= 4'd0;
      r_frameCnt    <= 8'd0;
      r_destH       <= 12'd0;
      r_destV       <= 12'd0;
      r_color       <= 4'd0;
      r_visible     <= 1'b0;
      r_playerReset <= 1'b0;
      r_gameWon     <= 1'b0;
    end else begin
      r_playerReset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_visible <= 1'b0;
          if (i_start) begin
            r_levelNum <= 4'd0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_destH       <= w_entry.hPos;
          r_destV       <= w_entry.vPos;
          r_color       <= w_entry.color;
          r_playerReset <= 1'b1;
          r_visible     <= 1'b1;
          r_state       <= ST_PLAY;
        end
        ST_PLAY: begin
          r_visible <= 1'b1;
          if (w_rise) begin
            r_frameCnt <= 8'd0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_frame_tick) begin
            if (r_frameCnt == LAST_FRAME) begin
              r_visible <= 1'b0;
              if (w_lastLevel) begin
                r_gameWon <= 1'b1;
                r_state   <= ST_WON;
              end else begin
                r_levelNum <= r_levelNum + 4'd1;
                r_state    <= ST_LOAD;
              end
            end else begin
              // Blink period is 8 frames on, 8 frames off, starting on.
              r_frameCnt <= w_frameNext;
              r_visible  <= ~w_frameNext[3];
            end
          end
        end
        ST_WON: begin
          r_visible <= 1'b0;
          if (i_start) begin
            r_levelNum <= 4'd0;
            r_gameWon  <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dest_hPos    = r_destH;
  assign o_dest_vPos    = r_destV;
  assign o_rect_color   = r_color;
  assign o_visible      = r_visible;
  assign o_level_num    = r_levelNum;
  assign o_player_reset = r_playerReset;
  assign o_game_won     = r_gameWon;

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, default 4, number of levels in the destination table (2..16).
REQ-002 Parameter HOLD_FRAMES, default 60, frames the completion display lasts before the next level loads (1..255).
REQ-003 clk  in  1  system clock; every register updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  game-start request, sampled each clk.
REQ-006 frame_tick  in  1  one-clk pulse per video frame.
REQ-007 level_complete  in  1  player-on-destination flag from the destination-rectangle stage; combinational and may stay high for many cycles.
REQ-008 dest_hPos  out  12  destination rectangle horizontal start position.
REQ-009 dest_vPos  out  12  destination rectangle vertical start position.
REQ-010 rect_color  out  4  destination rectangle color.
REQ-011 visible  out  1  destination rectangle visibility.
REQ-012 level_num  out  4  current level index, zero-based.
REQ-013 player_reset  out  1  one-clk pulse that returns the player to spawn.
REQ-014 game_won  out  1  high while in the WON state.

Function
REQ-015 States: IDLE, LOAD, PLAY, HOLD, WON; each state is exactly one of these (one-hot or encoded), all outputs registered.
REQ-016 IDLE: visible=0; start=1 -> level_num=0, go to LOAD next cycle.
REQ-017 LOAD lasts exactly 1 cycle:
  - load dest_hPos, dest_vPos and rect_color from table[level_num];
  - assert player_reset for that cycle only;
  - clear the level_complete history register to 0;
  - go to PLAY.
REQ-018 PLAY: visible=1; a rising edge of level_complete (current=1, registered previous=0) -> go to HOLD and clear frame_cnt to 0.
REQ-019 level_complete is ignored in every state except PLAY; a level held high from a prior level does not advance a level, because an edge is required.
REQ-020 HOLD:
  - frame_cnt (8-bit) increments on frame_tick;
  - visible = frame_cnt[3] inverted, so it blinks every 8 frames, starting visible;
  - when frame_tick arrives with frame_cnt==HOLD_FRAMES-1: if level_num==NUM_LEVELS-1 go to WON, else increment level_num and go to LOAD.
REQ-021 WON: game_won=1, visible=0, dest/color hold their last values; start=1 -> level_num=0, go to LOAD.
REQ-022 start is ignored in LOAD, PLAY and HOLD.
REQ-023 level_num never exceeds NUM_LEVELS-1; there is no wrap from the last level except through WON -> start.
REQ-024 Latency:
  - level_complete edge -> HOLD state: 1 clk;
  - final HOLD tick -> player_reset pulse: 2 clk (via LOAD).

Reset
REQ-025 With rst=0, asynchronously:
  - state=IDLE, level_num=0, frame_cnt=0, level_complete history=0;
  - dest_hPos=0, dest_vPos=0, rect_color=0;
  - visible=0, player_reset=0, game_won=0.
REQ-026 Deasserting rst mid-HOLD or mid-PLAY always resumes in IDLE; no partial level state survives.

Structure
REQ-027 The state enum, the level table (hPos, vPos, color per level) and the default constants live in a shared game package.
REQ-028 Table entries, in order:
  - level 0: (100,80) color 2;
  - level 1: (500,300) color 4;
  - level 2: (620,420) color 9;
  - level 3: (40,440) color 12.
REQ-029 One sub-module, edge_detect (registered rising-edge detector with synchronous clear), is instantiated for level_complete.

Verification
REQ-030 Reset then start pulse -> after 1 clk LOAD:
  - dest=(100,80), color=2;
  - player_reset high for 1 clk;
  - visible=1 in PLAY.
REQ-031 In PLAY, level_complete 0->1 held 500 clk -> HOLD entered once; after 60 frame_ticks, level_num=1 and dest=(500,300).
REQ-032 In HOLD, observe visible over 60 frames -> it is 1 for frames 0-7, 0 for frames 8-15, and alternates every 8 frames thereafter.
REQ-033 Complete all 4 levels -> WON with game_won=1 and visible=0; start -> level_num=0 and dest=(100,80).
REQ-034 level_complete already high when LOAD for level 1 occurs -> no advance until it drops and rises again.
REQ-035 rst asserted during HOLD at frame 30 -> all outputs at reset values immediately; after release, state IDLE with level_num=0.
